// File: rtl/two_digit_bcd_counter.sv
// Two-digit BCD up/down counter with a built-in prescaler. It drives the tens/ones
// nibble decoders directly and supports pause, direction, clear and a checked parallel load.
module two_digit_bcd_counter #(
    parameter int CLKS_PER_STEP = 25000000,
    parameter int MAX_COUNT     = 99
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Enable,
    input  logic       i_Up,
    input  logic       i_Clear,
    input  logic       i_Load,
    input  logic [3:0] i_Load_Tens,
    input  logic [3:0] i_Load_Ones,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Ones,
    output logic       o_Step,
    output logic       o_Wrap,
    output logic       o_Load_Err
);

    localparam int              PW       = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam logic [PW-1:0]   TERM     = PW'(CLKS_PER_STEP - 1);
    localparam logic [3:0]      MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0]      MAX_ONES = 4'(MAX_COUNT % 10);
    localparam logic [7:0]      MAX_VAL  = 8'(MAX_COUNT);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic          lerr_q, lerr_d;

    logic [7:0]    load_val;
    logic          load_ok;
    logic          at_max;
    logic          at_zero;

    // Tens can be up to 15 on a bad load, so the weighted value needs 8 bits.
    assign load_val = ({4'd0, i_Load_Tens} << 3) + ({4'd0, i_Load_Tens} << 1)
                    + {4'd0, i_Load_Ones};
    assign load_ok  = (i_Load_Tens <= 4'd9) && (i_Load_Ones <= 4'd9) && (load_val <= MAX_VAL);
    assign at_max   = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        lerr_d  = 1'b0;
        if (i_Clear) begin
            presc_d = '0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (i_Load) begin
            presc_d = '0;
            if (load_ok) begin
                tens_d = i_Load_Tens;
                ones_d = i_Load_Ones;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (i_Enable) begin
            if (presc_q == TERM) begin
                presc_d = '0;
                step_d  = 1'b1;
                if (i_Up) begin
                    if (at_max) begin
                        tens_d = 4'd0;
                        ones_d = 4'd0;
                        wrap_d = 1'b1;
                    end else if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end else begin
                    if (at_zero) begin
                        tens_d = MAX_TENS;
                        ones_d = MAX_ONES;
                        wrap_d = 1'b1;
                    end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            presc_q <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            lerr_q  <= lerr_d;
        end
    end

    assign o_Tens     = tens_q;
    assign o_Ones     = ones_q;
    assign o_Step     = step_q;
    assign o_Wrap     = wrap_q;
    assign o_Load_Err = lerr_q;

endmodule

// File: tb/tb_two_digit_bcd_counter.sv
// Bench for two_digit_bcd_counter: directed scenarios plus random stimulus, all checked
// against an integer-valued model of the decimal count and step timing.
module tb_two_digit_bcd_counter;

    localparam int CPS = 4;
    localparam int MAX = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b1, clr = 1'b0, ld = 1'b0;
    logic [3:0] ld_t = 4'd0, ld_o = 4'd0;
    logic [3:0] o_tens, o_ones;
    logic       o_step, o_wrap, o_lerr;

    int total = 0;
    int bad   = 0;

    // model state: the count is a plain integer 0..MAX, digits derived by /10 and %10
    int m_val = 0;
    int m_cyc = 0;
    bit m_step = 0, m_wrap = 0, m_err = 0;

    two_digit_bcd_counter #(.CLKS_PER_STEP(CPS), .MAX_COUNT(MAX)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Up(up), .i_Clear(clr),
        .i_Load(ld), .i_Load_Tens(ld_t), .i_Load_Ones(ld_o),
        .o_Tens(o_tens), .o_Ones(o_ones), .o_Step(o_step), .o_Wrap(o_wrap),
        .o_Load_Err(o_lerr)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_vec();
        return {4'(m_val / 10), 4'(m_val % 10), m_step, m_wrap, m_err};
    endfunction

    function automatic logic [10:0] act_vec();
        return {o_tens, o_ones, o_step, o_wrap, o_lerr};
    endfunction

    task automatic model_reset();
        m_val = 0; m_cyc = 0; m_step = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int lv;
        m_step = 0; m_wrap = 0; m_err = 0;
        if (!rst_n) begin
            model_reset();
        end else if (clr) begin
            m_val = 0; m_cyc = 0;
        end else if (ld) begin
            m_cyc = 0;
            lv = int'(ld_t) * 10 + int'(ld_o);
            if (ld_t <= 9 && ld_o <= 9 && lv <= MAX) m_val = lv;
            else m_err = 1;
        end else if (en) begin
            m_cyc++;
            if (m_cyc == CPS) begin
                m_cyc = 0;
                m_step = 1;
                if (up) begin
                    m_wrap = (m_val == MAX);
                    m_val = (m_val + 1) % (MAX + 1);
                end else begin
                    m_wrap = (m_val == 0);
                    m_val = (m_val + MAX) % (MAX + 1);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        repeat (2) cyc();
        total++;
        if (act_vec() !== 11'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want 000", act_vec());
        end
        rst_n = 1;
    endtask

    task automatic test_count_up();
        int steps = 0, wraps = 0;
        en = 1; up = 1;
        for (int i = 0; i < CPS * 14; i++) begin
            cyc();
            steps += int'(o_step);
            wraps += int'(o_wrap);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL count_up cyc%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        total++;
        if (steps != 14 || wraps != 1) begin
            bad++;
            $display("FAIL count_up_pulses: got steps=%0d wraps=%0d want 14/1", steps, wraps);
        end
    endtask

    task automatic test_count_down();
        int wraps = 0;
        clr = 1; cyc(); clr = 0;
        up = 0; en = 1;
        for (int i = 0; i < CPS * 4; i++) begin
            cyc();
            wraps += int'(o_wrap);
            if (i == CPS - 1) begin
                total++;
                if ({o_tens, o_ones, o_wrap} !== {4'd1, 4'd2, 1'b1}) begin
                    bad++;
                    $display("FAIL down_wrap: got %h%h w=%b want 12 w=1", o_tens, o_ones, o_wrap);
                end
            end
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL count_down cyc%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        total++;
        if ({o_tens, o_ones} !== 8'h09 || wraps != 1) begin
            bad++;
            $display("FAIL down_borrow: got %h%h wraps=%0d want 09/1", o_tens, o_ones, wraps);
        end
    endtask

    task automatic test_enable_hold();
        up = 1; en = 1;
        clr = 1; cyc(); clr = 0;
        repeat (2) cyc();
        en = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (act_vec() !== exp_vec() || o_step !== 1'b0) begin
                bad++;
                $display("FAIL enable_hold cyc%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        en = 1;
        cyc();
        total++;
        if (o_step !== 1'b0) begin
            bad++;
            $display("FAIL resume_early: got step=%b want 0", o_step);
        end
        cyc();
        total++;
        if (o_step !== 1'b1 || {o_tens, o_ones} !== 8'h01) begin
            bad++;
            $display("FAIL resume_step: got step=%b val=%h%h want 1/01", o_step, o_tens, o_ones);
        end
    endtask

    task automatic test_load();
        en = 0;
        ld = 1; ld_t = 4'd1; ld_o = 4'd1; cyc(); ld = 0;
        total++;
        if (act_vec() !== {8'h11, 3'b000}) begin
            bad++;
            $display("FAIL load_ok: got %h want %h", act_vec(), {8'h11, 3'b000});
        end
        ld = 1; ld_t = 4'd1; ld_o = 4'd3; cyc(); ld = 0;
        total++;
        if (act_vec() !== {8'h11, 3'b001}) begin
            bad++;
            $display("FAIL load_over_max: got %h want %h", act_vec(), {8'h11, 3'b001});
        end
        ld = 1; ld_t = 4'd0; ld_o = 4'hA; cyc(); ld = 0;
        total++;
        if (act_vec() !== {8'h11, 3'b001}) begin
            bad++;
            $display("FAIL load_bad_digit: got %h want %h", act_vec(), {8'h11, 3'b001});
        end
        cyc();
        total++;
        if (act_vec() !== exp_vec() || o_lerr !== 1'b0) begin
            bad++;
            $display("FAIL load_err_pulse: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_clear_load_tc();
        int first = -1;
        up = 1; en = 1;
        clr = 1; cyc(); clr = 0;
        ld_t = 4'd0; ld_o = 4'd5;
        repeat (CPS - 1) cyc();
        clr = 1; ld = 1; cyc(); clr = 0; ld = 0;
        total++;
        if (act_vec() !== 11'd0) begin
            bad++;
            $display("FAIL clear_at_tc: got %h want 000", act_vec());
        end
        for (int i = 1; i <= CPS + 1 && first < 0; i++) begin
            cyc();
            if (o_step) first = i;
        end
        total++;
        if (first != CPS) begin
            bad++;
            $display("FAIL step_after_clear: got %0d want %0d", first, CPS);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        up = 1; en = 1;
        clr = 1; cyc(); clr = 0;
        while (m_val != 7 && guard < 100) begin cyc(); guard++; end
        repeat (2) cyc();
        total++;
        if ({o_tens, o_ones} !== 8'h07) begin
            bad++;
            $display("FAIL pre_reset_val: got %h%h want 07", o_tens, o_ones);
        end
        #2 rst_n = 0;
        #1;
        model_reset();
        total++;
        if (act_vec() !== 11'd0) begin
            bad++;
            $display("FAIL async_reset: got %h want 000", act_vec());
        end
        cyc();
        rst_n = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 7) != 0);
            up   = $urandom_range(0, 1);
            clr  = ($urandom_range(0, 29) == 0);
            ld   = ($urandom_range(0, 19) == 0);
            ld_t = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            ld_o = 4'($urandom_range(0, 11));
            cyc();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        clr = 0; ld = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count_up();
        test_count_down();
        test_enable_hold();
        test_load();
        test_clear_load_tc();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
